instruction_fetch_unit: RTL

//  Fetch-side initiator for the byte-addressed, big-endian instruction memory (32-bit word, 1-cycle registered read).

---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 66 ++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-unit bundle: decode handshake, redirect and instruction memory port
interface instruction_fetch_unit_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  stall;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_data;
   logic                  if_valid;
   logic [31:0]           if_instr;
   logic [ADDR_WIDTH-1:0] if_pc;
   logic [ADDR_WIDTH-1:0] if_pc_plus4;
   logic                  misalign_err;
   logic [CNT_WIDTH-1:0]  fetch_count;

   modport master (
      input  stall, redirect_valid, redirect_target, imem_data,
      output imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, misalign_err, fetch_count
   );

   modport slave (
      output stall, redirect_valid, redirect_target, imem_data,
      input  imem_addr, if_valid, if_instr, if_pc, if_pc_plus4, misalign_err, fetch_count
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and fetch-to-decode handshake for a 1-cycle registered instruction memory
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    CNT_WIDTH  = 16
) (
   input logic                      clock,
   input logic                      reset,
   instruction_fetch_unit_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [ADDR_WIDTH-1:0] tgt;
   logic                  req_valid;
   logic                  hold;
   logic                  accept;
   logic                  misalign_err;
   logic [CNT_WIDTH-1:0]  fetch_count;

   assign tgt    = {bus.redirect_target[ADDR_WIDTH-1:2], 2'b00};
   assign hold   = bus.stall && req_valid;
   assign accept = req_valid && !bus.stall && !bus.redirect_valid;

   // Re-reading req_pc while held keeps imem_data stable for decode.
   always_comb begin
      bus.imem_addr = pc;
      if (bus.redirect_valid) begin
         bus.imem_addr = tgt;
      end else if (hold) begin
         bus.imem_addr = req_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc           <= RESET_PC;
         req_pc       <= RESET_PC;
         req_valid    <= 1'b0;
         fetch_count  <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
         if (accept) begin
            fetch_count <= fetch_count + 1'b1;
         end
         if (bus.redirect_valid) begin
            req_pc    <= tgt;
            req_valid <= 1'b1;
            pc        <= tgt + PC_STEP;
         end else if (!hold) begin
            req_pc    <= pc;
            req_valid <= 1'b1;
            pc        <= pc + PC_STEP;
         end
      end
   end

   assign bus.if_valid     = req_valid;
   assign bus.if_pc        = req_pc;
   assign bus.if_pc_plus4  = req_pc + PC_STEP;
   assign bus.if_instr     = req_valid ? bus.imem_data : 32'h0;
   assign bus.misalign_err = misalign_err;
   assign bus.fetch_count  = fetch_count;
endmodule
